fetch_stage: RTL and testbench

Instruction-fetch stage that replaces the free-running PC/adder/IF-ID chain in front of decode.
- Owns the fetch address and issues word requests to a variable-latency instruction memory over a req/ready handshake.
- Loads the IF/ID pipeline register (instruction, PC, valid) consumed by decode.
- Honours a decode stall from the load-use hazard logic and a branch/jump redirect, using a one-entry skid buffer and squashing of in-flight requests.

---
 rtl/fetch_pkg.sv | 31 +++
 rtl/fetch_skid_buffer.sv | 45 ++++
 rtl/fetch_stage.sv | 161 ++++++++++++++++
 tb/tb_fetch_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_t : fetch sequencer states (BOOT / FETCH / HOLD)
//   ifid_entry_t  : one {instruction, pc} pair as held in IF/ID or the skid
//   PC_STEP       : byte distance between sequential instruction words
//   DEFAULT_BUBBLE_INST : MIPS nop, loaded into IF/ID as a bubble
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ifid_entry_t;

  localparam logic [31:0] PC_STEP             = 32'd4;
  localparam logic [31:0] DEFAULT_BUBBLE_INST = 32'h0000_0000;

  // Instruction addresses are word addresses; the two byte-offset bits of an
  // externally supplied target are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// -----------------------------------------------------------------------------
// fetch_skid_buffer
// One-entry holding register for an instruction that returned from memory
// while decode was stalled. Clear has priority over load.
// Ports:
//   clock, resetn : clock and asynchronous active-low reset
//   i_load        : capture i_entry and mark the buffer valid
//   i_clear       : drop the held entry
//   i_entry       : {inst, pc} to capture
//   o_valid       : buffer holds an entry
//   o_entry       : held {inst, pc}
// -----------------------------------------------------------------------------
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        i_load,
  input  logic        i_clear,
  input  ifid_entry_t i_entry,
  output logic        o_valid,
  output ifid_entry_t o_entry
);

  logic        r_valid;
  ifid_entry_t r_entry;

  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: the payload is reset along with the valid bit; it is a single
    // register, not a RAM, so the reset costs nothing and keeps X out of IF/ID.
    if (!resetn) begin
      r_valid <= 1'b0;
      r_entry <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_entry <= i_entry;
    end
  end

  assign o_valid = r_valid;
  assign o_entry = r_entry;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the fetch address, issues one word request at
// a time to a variable-latency instruction memory, and loads the IF/ID
// register consumed by decode. Handles decode stalls through a one-entry skid
// buffer and branch/jump redirects by squashing an in-flight request.
// Parameters:
//   RESET_PC    : first fetch address after reset
//   BUBBLE_INST : instruction word shown in IF/ID when it holds a bubble
// Ports:
//   clock, resetn          : clock, asynchronous active-low reset
//   imem_req / imem_addr   : request valid and word address (stable while waiting)
//   imem_ready / imem_rdata: memory completes the transfer / returned word
//   stall                  : decode cannot accept, IF/ID holds
//   redirect / redirect_pc : taken branch/jump and its target
//   dinst / dpc / dvalid   : IF/ID instruction, address, valid
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INST = DEFAULT_BUBBLE_INST
) (
  input  logic        clock,
  input  logic        resetn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] dinst,
  output logic [31:0] dpc,
  output logic        dvalid
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic [31:0] r_faddr;
  logic [31:0] r_tgt;
  logic        r_squash;
  logic [31:0] r_dinst;
  logic [31:0] r_dpc;
  logic        r_dvalid;

  logic        w_xfer;
  logic        w_skid_load;
  logic        w_skid_clear;
  logic        w_skid_valid;
  ifid_entry_t w_skid_out;
  logic [31:0] w_redirect_pc;

  // Ready only counts while a request is actually outstanding.
  assign w_xfer        = (r_state == FETCH) && imem_ready;
  assign w_redirect_pc = word_align(redirect_pc);

  // A returned word is parked only when it is on the correct path and decode
  // is stalled; a redirect or leaving HOLD empties the buffer.
  assign w_skid_load  = !redirect && w_xfer && !r_squash && stall;
  assign w_skid_clear = redirect || ((r_state == HOLD) && !stall);

  fetch_skid_buffer u_skid (
    .clock   (clock),
    .resetn  (resetn),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_entry ('{inst: imem_rdata, pc: r_faddr}),
    .o_valid (w_skid_valid),
    .o_entry (w_skid_out)
  );

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (!resetn) r_state <= BOOT;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; a redirect always resumes fetching.
  always_comb begin
    // NOTE: the default-first assignment keeps this block free of latches.
    w_state_nxt = r_state;
    if (redirect) begin
      w_state_nxt = FETCH;
    end else begin
      unique case (r_state)
        BOOT:    w_state_nxt = FETCH;
        FETCH:   if (w_xfer && !r_squash && stall) w_state_nxt = HOLD;
        HOLD:    if (!stall) w_state_nxt = FETCH;
        default: w_state_nxt = BOOT;
      endcase
    end
  end

  // Outputs: a request is outstanding in every FETCH cycle.
  always_comb begin
    imem_req = (r_state == FETCH);
  end

  assign imem_addr = r_faddr;

  // Fetch address, pending redirect target and squash flag. While a request
  // is waiting its address must not move, so a redirect is parked in r_tgt
  // and applied when the doomed transfer completes.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_faddr  <= RESET_PC;
      r_tgt    <= '0;
      r_squash <= 1'b0;
    end else if (redirect) begin
      if ((r_state == FETCH) && !w_xfer) begin
        r_squash <= 1'b1;
        r_tgt    <= w_redirect_pc;
      end else begin
        r_faddr  <= w_redirect_pc;
        r_squash <= 1'b0;
      end
    end else if (w_xfer) begin
      if (r_squash) begin
        r_faddr  <= r_tgt;
        r_squash <= 1'b0;
      end else begin
        r_faddr  <= r_faddr + PC_STEP;
      end
    end
  end

  // IF/ID register. Any cycle decode accepts without a new instruction to
  // give it becomes a bubble; dpc keeps its last value in a bubble.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_dinst  <= BUBBLE_INST;
      r_dpc    <= '0;
      r_dvalid <= 1'b0;
    end else if (redirect) begin
      r_dinst  <= BUBBLE_INST;
      r_dvalid <= 1'b0;
    end else if (!stall) begin
      if (r_state == HOLD) begin
        r_dinst  <= w_skid_out.inst;
        r_dpc    <= w_skid_out.pc;
        r_dvalid <= w_skid_valid;
      end else if (w_xfer && !r_squash) begin
        r_dinst  <= imem_rdata;
        r_dpc    <= r_faddr;
        r_dvalid <= 1'b1;
      end else begin
        r_dinst  <= BUBBLE_INST;
        r_dvalid <= 1'b0;
      end
    end
  end

  assign dinst  = r_dinst;
  assign dpc    = r_dpc;
  assign dvalid = r_dvalid;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage. A behavioural memory answers each
// request after a chosen latency; a decode-side scoreboard tracks the address
// of the next architecturally correct instruction and checks every consumed
// IF/ID entry against it, plus hold/bubble/address-stability rules.
// -----------------------------------------------------------------------------
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] BUBBLE = DEFAULT_BUBBLE_INST;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] dinst;
  logic [31:0] dpc;
  logic        dvalid;

  int n_vec = 0;
  int n_bad = 0;

  // Previous-cycle snapshot of DUT outputs and driven inputs.
  logic        p_req, p_ready, p_stall, p_redir, p_dvalid;
  logic [31:0] p_addr, p_rpc, p_dinst, p_dpc;

  logic [31:0] exp_pc;
  int          wait_cnt = 0;
  int          lat = 0;
  int          fixed_lat = 0;
  int          consumed = 0;
  logic [31:0] req_log[$];

  always #5 clock = ~clock;

  fetch_stage #(
    .RESET_PC    (RST_PC),
    .BUBBLE_INST (BUBBLE)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dinst       (dinst),
    .dpc         (dpc),
    .dvalid      (dvalid)
  );

  // Memory contents: a fixed, never-zero function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic snap();
    p_req    = imem_req;
    p_ready  = imem_ready;
    p_addr   = imem_addr;
    p_stall  = stall;
    p_redir  = redirect;
    p_rpc    = redirect_pc;
    p_dvalid = dvalid;
    p_dinst  = dinst;
    p_dpc    = dpc;
  endtask

  // Pulse reset mid-cycle, check the asynchronous reset values, release.
  task automatic do_reset();
    @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_addr",  imem_addr,     RST_PC);
    check("rst_valid", 32'(dvalid),   32'd0);
    check("rst_inst",  dinst,         BUBBLE);
    check("rst_pc",    dpc,           32'd0);
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ready  = 1'b0;
    imem_rdata  = '0;
    @(negedge clock);
    resetn = 1'b1;
    check("boot_req", 32'(imem_req), 32'd0);
    exp_pc = RST_PC;
    snap();
  endtask

  // One clock: judge the edge just taken, then drive the next inputs.
  task automatic tick(input logic s, input logic r, input logic [31:0] rpc);
    @(negedge clock);
    if (p_req && !p_ready) begin
      check("req_held",    32'(imem_req), 32'd1);
      check("addr_stable", imem_addr,     p_addr);
    end
    if (p_redir) begin
      exp_pc = {p_rpc[31:2], 2'b00};
      check("redir_bubble", 32'(dvalid), 32'd0);
    end else if (p_stall) begin
      check("hold_valid", 32'(dvalid), 32'(p_dvalid));
      check("hold_pc",    dpc,         p_dpc);
      check("hold_inst",  dinst,       p_dinst);
    end else if (p_dvalid) begin
      check("seq_pc",   p_dpc,   exp_pc);
      check("seq_inst", p_dinst, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    if (dvalid !== 1'b1) check("bubble_inst", dinst, BUBBLE);
    // Memory: a new request starts when req rises or follows a transfer.
    if (imem_req) begin
      if (!p_req || p_ready) begin
        wait_cnt = 0;
        lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        req_log.push_back(imem_addr);
      end
      imem_ready = (wait_cnt >= lat);
      wait_cnt++;
    end else begin
      imem_ready = 1'($urandom_range(0, 1));
    end
    imem_rdata  = imem_ready ? mem_word(imem_addr) : $urandom;
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    snap();
  endtask

  initial begin
    int n;

    // Zero-latency memory: back-to-back delivery from RESET_PC.
    fixed_lat = 0;
    do_reset();
    tick(1'b0, 1'b0, '0);
    check("first_req",  32'(imem_req), 32'd1);
    check("first_addr", imem_addr,     32'h0);
    check("first_bub",  32'(dvalid),   32'd0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, '0);
      check("stream_valid", 32'(dvalid), 32'd1);
      check("stream_pc",    dpc,         32'(4 * i));
      check("stream_inst",  dinst,       mem_word(32'(4 * i)));
    end

    // Latency 3: valid pattern 0,0,1 with the address held while waiting.
    fixed_lat = 2;
    do_reset();
    repeat (3) tick(1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, '0);
      check("lat_valid1", 32'(dvalid), 32'd1);
      check("lat_pc",     dpc,         32'(4 * i));
      tick(1'b0, 1'b0, '0);
      check("lat_valid0a", 32'(dvalid), 32'd0);
      check("lat_addr",    imem_addr,   32'(4 * (i + 1)));
      tick(1'b0, 1'b0, '0);
      check("lat_valid0b", 32'(dvalid), 32'd0);
    end

    // Two-cycle stall landing on the transfer of 0x10.
    fixed_lat = 0;
    do_reset();
    repeat (4) tick(1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    check("stl_addr", imem_addr, 32'h10);
    tick(1'b1, 1'b0, '0);
    check("stl_hold_req", 32'(imem_req), 32'd0);
    check("stl_hold_pc",  dpc,           32'h0C);
    tick(1'b0, 1'b0, '0);
    check("stl_hold_req2", 32'(imem_req), 32'd0);
    check("stl_hold_pc2",  dpc,           32'h0C);
    tick(1'b0, 1'b0, '0);
    check("stl_skid_pc", dpc,       32'h10);
    check("stl_next",    imem_addr, 32'h14);
    repeat (3) tick(1'b0, 1'b0, '0);

    // Redirect to 0x100 while the 0x20 request waits (latency 4).
    do_reset();
    repeat (8) tick(1'b0, 1'b0, '0);
    fixed_lat = 3;
    tick(1'b0, 1'b0, '0);
    check("rd_pending", imem_addr, 32'h20);
    n = req_log.size();
    tick(1'b0, 1'b1, 32'h100);
    for (int i = 0; i < 20 && dvalid !== 1'b1; i++) tick(1'b0, 1'b0, '0);
    check("rd_first_valid", 32'(dvalid), 32'd1);
    check("rd_first_pc",    dpc,         32'h100);
    check("rd_next_req", (req_log.size() > n) ? req_log[n] : 32'hDEAD_BEEF, 32'h100);

    // Redirect together with stall while in HOLD.
    fixed_lat = 0;
    do_reset();
    repeat (4) tick(1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b1, 32'h200);
    check("hr_in_hold", 32'(imem_req), 32'd0);
    tick(1'b0, 1'b0, '0);
    check("hr_bubble", 32'(dvalid), 32'd0);
    check("hr_req",    imem_addr,   32'h200);
    tick(1'b0, 1'b0, '0);
    check("hr_valid", 32'(dvalid), 32'd1);
    check("hr_pc",    dpc,         32'h200);

    // Reset mid-wait, then redirect to the top word and wrap.
    fixed_lat = 3;
    do_reset();
    repeat (2) tick(1'b0, 1'b0, '0);
    do_reset();
    fixed_lat = 0;
    tick(1'b0, 1'b1, 32'hFFFF_FFFF);
    check("wr_addr0", imem_addr, 32'h0);
    tick(1'b0, 1'b0, '0);
    check("wr_addr1",  imem_addr,  32'hFFFF_FFFC);
    check("wr_bubble", 32'(dvalid), 32'd0);
    tick(1'b0, 1'b0, '0);
    check("wr_pc_top", dpc,       32'hFFFF_FFFC);
    check("wr_addr2",  imem_addr, 32'h0);
    tick(1'b0, 1'b0, '0);
    check("wr_pc_zero", dpc,       32'h0);
    check("wr_addr3",   imem_addr, 32'h4);

    // Randomised traffic: latency, stalls, redirects.
    fixed_lat = -1;
    for (int blk = 0; blk < 3; blk++) begin
      do_reset();
      for (int c = 0; c < 1000; c++) begin
        logic        s, r;
        logic [31:0] t;
        s = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 15) == 0);
        t = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 1023);
        tick(s, r, t);
      end
    end
    tick(1'b0, 1'b0, '0);
    check("progress", 32'(consumed >= 300), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
